// File: rtl/ps2_drive_cmd_scheduler.sv
// ps2_drive_cmd_scheduler: decodes PS/2 make/break/extended byte sequences into accel/steer drive commands.
// Optional silent-bus watchdog release is enabled by defining PS2_DRIVE_WATCHDOG_EN.
module ps2_drive_cmd_scheduler #(
    parameter logic [7:0] FWD_CODE   = 8'h75,
    parameter logic [7:0] BACK_CODE  = 8'h72,
    parameter logic [7:0] LEFT_CODE  = 8'h6B,
    parameter logic [7:0] RIGHT_CODE = 8'h74
`ifdef PS2_DRIVE_WATCHDOG_EN
    , parameter int TIMEOUT_CYCLES = 100_000_000
`endif
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_byte_en,
    output logic [1:0] accel,
    output logic [1:0] steer,
    output logic [3:0] keys_held,
    output logic       cmd_valid,
    output logic       timeout_flag
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
    state_t state, state_n;
    logic [3:0] key, fresh, held_n;
    logic       make, brk, fire, win_a, win_s, win_a_n, win_s_n;
    logic [1:0] accel_n, steer_n;
    assign key = {ps2_byte == FWD_CODE, ps2_byte == BACK_CODE,
                  ps2_byte == LEFT_CODE, ps2_byte == RIGHT_CODE};
`ifdef PS2_DRIVE_WATCHDOG_EN
    logic [26:0] cnt;
    // Fires on the cycle the silent counter reaches the limit; only meaningful with a key held
    assign fire = !ps2_byte_en && cnt == 27'(TIMEOUT_CYCLES - 1) && |keys_held;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            timeout_flag <= 1'b0;
        end else begin
            cnt          <= ps2_byte_en ? '0 : cnt == 27'(TIMEOUT_CYCLES) ? cnt : cnt + 27'd1;
            timeout_flag <= fire;
        end
    end
`else
    assign fire         = 1'b0;
    assign timeout_flag = 1'b0;
`endif
    always_comb begin
        make    = ps2_byte_en && |key && (state == IDLE || state == EXT);
        brk     = ps2_byte_en && |key && (state == BRK || state == EXT_BRK);
        state_n = !ps2_byte_en ? state :
                  state == IDLE ? (ps2_byte == 8'hE0 ? EXT : ps2_byte == 8'hF0 ? BRK : IDLE) :
                  state == EXT  ? (ps2_byte == 8'hF0 ? EXT_BRK : IDLE) : IDLE;
        state_n = fire ? IDLE : state_n;
        held_n  = fire ? 4'b0 : make ? keys_held | key : brk ? keys_held & ~key : keys_held;
        // Only a genuinely new press claims its axis; typematic repeats leave the winner alone
        fresh   = key & ~keys_held & {4{make}};
        win_a_n = fresh[3] ? 1'b1 : fresh[2] ? 1'b0 : win_a;
        win_s_n = fresh[1] ? 1'b1 : fresh[0] ? 1'b0 : win_s;
        accel_n = &held_n[3:2] ? (win_a_n ? 2'b10 : 2'b01) : held_n[3:2];
        steer_n = &held_n[1:0] ? (win_s_n ? 2'b10 : 2'b01) : held_n[1:0];
    end
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            keys_held <= 4'b0;
            win_a     <= 1'b0;
            win_s     <= 1'b0;
            accel     <= 2'b00;
            steer     <= 2'b00;
            cmd_valid <= 1'b0;
        end else begin
            state     <= state_n;
            keys_held <= held_n;
            win_a     <= win_a_n;
            win_s     <= win_s_n;
            accel     <= accel_n;
            steer     <= steer_n;
            cmd_valid <= {accel_n, steer_n} != {accel, steer};
        end
    end
endmodule

// File: tb/tb_ps2_drive_cmd_scheduler.sv
// tb_ps2_drive_cmd_scheduler: directed and random byte streams checked against a timestamp-based key model.
// Define PS2_DRIVE_WATCHDOG_EN to exercise the watchdog release with a 1000-cycle timeout.
module tb_ps2_drive_cmd_scheduler;
    logic       CLOCK_50, resetn, ps2_byte_en, cmd_valid, timeout_flag;
    logic [7:0] ps2_byte;
    logic [1:0] accel, steer;
    logic [3:0] keys_held;
    int n_cmp, n_bad;
`ifdef PS2_DRIVE_WATCHDOG_EN
    localparam int T = 1000;
    ps2_drive_cmd_scheduler #(.TIMEOUT_CYCLES(T)) dut (
`else
    localparam int T = 0;
    ps2_drive_cmd_scheduler dut (
`endif
        .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_byte(ps2_byte), .ps2_byte_en(ps2_byte_en),
        .accel(accel), .steer(steer), .keys_held(keys_held), .cmd_valid(cmd_valid),
        .timeout_flag(timeout_flag));
    initial begin
        CLOCK_50 = 0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end
    // Model: a key is held while its press stamp is nonzero; the later stamp wins an axis
    int ts[4];
    int stamp, idle;
    bit e_ext, e_brk, e_cmd, e_flag;
    logic [1:0] e_accel, e_steer;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int keyidx(input logic [7:0] b);
        return b == 8'h75 ? 3 : b == 8'h72 ? 2 : b == 8'h6B ? 1 : b == 8'h74 ? 0 : -1;
    endfunction
    function automatic logic [1:0] axis(input int a, input int b);
        if (a > 0 && b > 0) return a > b ? 2'b10 : 2'b01;
        return {a > 0, b > 0};
    endfunction
    function automatic logic [3:0] e_keys();
        return {ts[3] > 0, ts[2] > 0, ts[1] > 0, ts[0] > 0};
    endfunction
    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) ts[i] = 0;
        stamp = 0; idle = 0; e_ext = 0; e_brk = 0; e_cmd = 0; e_flag = 0;
        e_accel = 2'b00; e_steer = 2'b00;
    endtask
    task automatic mdl(input bit en, input logic [7:0] b);
        logic [3:0] pv;
        int k;
        pv = {e_accel, e_steer};
        k = keyidx(b);
        e_flag = 0;
        if (en) begin
            idle = 0;
            if (e_brk) begin
                if (k >= 0) ts[k] = 0;
                e_brk = 0; e_ext = 0;
            end else if (b == 8'hF0) e_brk = 1;
            else if (b == 8'hE0 && !e_ext) e_ext = 1;
            else begin
                if (k >= 0 && ts[k] == 0) begin stamp++; ts[k] = stamp; end
                e_ext = 0;
            end
        end else if (T > 0 && idle < T) begin
            idle++;
            if (idle == T && e_keys() != 4'b0) begin
                for (int i = 0; i < 4; i++) ts[i] = 0;
                e_ext = 0; e_brk = 0; e_flag = 1;
            end
        end
        e_accel = axis(ts[3], ts[2]);
        e_steer = axis(ts[1], ts[0]);
        e_cmd = {e_accel, e_steer} != pv;
    endtask
    task automatic step(input bit en, input logic [7:0] b);
        ps2_byte_en = en; ps2_byte = b;
        @(posedge CLOCK_50); #1;
        ps2_byte_en = 0;
        mdl(en, b);
        check("keys_held", 8'(keys_held), 8'(e_keys()));
        check("accel", 8'(accel), 8'(e_accel));
        check("steer", 8'(steer), 8'(e_steer));
        check("cmd_valid", 8'(cmd_valid), 8'(e_cmd));
        check("timeout_flag", 8'(timeout_flag), 8'(e_flag));
    endtask
    task automatic seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
        step(1, a);
        if (n > 1) step(1, b);
        if (n > 2) step(1, c);
    endtask
    initial begin
        logic [7:0] pool [8] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'h1C, 8'hAA};
        int pulses;
        n_cmp = 0; n_bad = 0;
        resetn = 0; ps2_byte_en = 0; ps2_byte = 8'h00;
        mdl_reset();
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("rst_accel", 8'(accel), 8'h0);
        check("rst_steer", 8'(steer), 8'h0);
        check("rst_keys", 8'(keys_held), 8'h0);
        check("rst_cmd", 8'(cmd_valid), 8'h0);
        resetn = 1;
        step(1, 8'h75);
        check("t1_make", 8'(accel), 8'h2);
        check("t1_pulse", 8'(cmd_valid), 8'h1);
        step(0, 8'h00);
        check("t1_pulse_end", 8'(cmd_valid), 8'h0);
        seq(8'hF0, 8'h75, 0, 2);
        check("t1_break", 8'(accel), 8'h0);
        seq(8'hE0, 8'h75, 0, 2);
        check("t2_ext_make", 8'(accel), 8'h2);
        seq(8'hE0, 8'hF0, 8'h75, 3);
        check("t2_ext_break", 8'(accel), 8'h0);
        step(1, 8'h72);
        check("t2_back", 8'(accel), 8'h1);
        seq(8'hF0, 8'h72, 0, 2);
        seq(8'h75, 8'h72, 0, 2);
        check("t3_back_wins", 8'(accel), 8'h1);
        seq(8'hF0, 8'h72, 0, 2);
        check("t3_fwd_back", 8'(accel), 8'h2);
        check("t3_keys", 8'(keys_held), 8'h8);
        seq(8'hF0, 8'h75, 0, 2);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 8'h6B);
            pulses += int'(cmd_valid);
        end
        check("t4_pulses", 8'(pulses), 8'd1);
        check("t4_steer", 8'(steer), 8'h2);
        seq(8'hF0, 8'h74, 0, 2);
        check("t4_noop_steer", 8'(steer), 8'h2);
        step(1, 8'hF0);
        #2 resetn = 0;
        #1;
        check("t5_async_keys", 8'(keys_held), 8'h0);
        check("t5_async_steer", 8'(steer), 8'h0);
        @(posedge CLOCK_50); #1;
        resetn = 1;
        mdl_reset();
        step(1, 8'h75);
        check("t5_make_after_rst", 8'(accel), 8'h2);
        step(1, 8'h1C);
        check("t5_unmapped", 8'(accel), 8'h2);
        seq(8'hF0, 8'h75, 0, 2);
        step(1, 8'h75);
        for (int i = 0; i < 1000; i++) step(0, 8'h00);
`ifdef PS2_DRIVE_WATCHDOG_EN
        check("t6_flag", 8'(timeout_flag), 8'h1);
        check("t6_accel", 8'(accel), 8'h0);
        check("t6_cmd", 8'(cmd_valid), 8'h1);
        for (int i = 0; i < 1100; i++) step(0, 8'h00);
`else
        check("t6_still_held", 8'(keys_held), 8'h8);
        seq(8'hF0, 8'h75, 0, 2);
`endif
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) < 7) step(1, pool[$urandom_range(0, 7)]);
            else step(0, 8'h00);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
